// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: APB3 master driven by a valid/ready command interface.
// Each accepted command becomes one SETUP + ACCESS transfer. A wait-state
// timeout aborts a stuck ACCESS phase. Every transfer ends with a one-cycle
// response pulse that carries read data and the slave error or timeout status.
// A saturating counter records how many responses reported an error.
//
// Ports:
//   pclk, presetn        clock, synchronous active-low reset
//   cmd_valid/cmd_ready  command handshake; cmd_write/cmd_addr/cmd_wdata payload
//   rsp_valid            one-cycle completion pulse
//   rsp_rdata/rsp_err/rsp_timeout  response fields, held until the next response
//   err_cnt              saturating count of responses with rsp_err=1
//   psel/penable/pwrite/paddr/pwdata  APB master outputs
//   pready/pslverr/prdata             APB slave inputs
module apb_master_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [7:0]        err_cnt,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic              pslverr,
  input  logic [DATA_W-1:0] prdata
);

  // Counter only needs to reach TIMEOUT-1; the abort fires before it could wrap.
  localparam int          WCW     = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam int          TLAST   = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [WCW-1:0] WC_LAST = TLAST[WCW-1:0];

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t             state_q;
  logic [WCW-1:0]     wait_cnt_q;
  logic               cmd_ready_q;
  logic               rsp_valid_q, rsp_err_q, rsp_timeout_q;
  logic [DATA_W-1:0]  rsp_rdata_q;
  logic [7:0]         err_cnt_q;
  logic               psel_q, penable_q, pwrite_q;
  logic [ADDR_W-1:0]  paddr_q;
  logic [DATA_W-1:0]  pwdata_q;

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
      err_cnt_q     <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            paddr_q     <= cmd_addr;
            pwrite_q    <= cmd_write;
            pwdata_q    <= cmd_write ? cmd_wdata : '0;
            psel_q      <= 1'b1;
            cmd_ready_q <= 1'b0;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          penable_q  <= 1'b1;
          wait_cnt_q <= '0;
          state_q    <= ACCESS;
        end
        ACCESS: begin
          // Completion is checked first so a late pready beats the timeout.
          if (pready || (TO_EN && wait_cnt_q == WC_LAST)) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            cmd_ready_q   <= 1'b1;
            state_q       <= IDLE;
            rsp_valid_q   <= 1'b1;
            rsp_timeout_q <= !pready;
            rsp_err_q     <= pready ? pslverr : 1'b1;
            rsp_rdata_q   <= (pready && !pwrite_q) ? prdata : '0;
            // Counter updates together with the pulse so it is current when seen.
            if ((!pready || pslverr) && err_cnt_q != 8'hFF)
              err_cnt_q <= err_cnt_q + 8'd1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign err_cnt     = err_cnt_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;

endmodule
